// File: rtl/i2c_target_responder.sv
// I2C target: filtered SCL/SDA, START/STOP detect, 7-bit address match, rx strobe / tx request byte interfaces.
// Latency: pad edge to internal edge pulse is 2 + FILTER_LEN cycles; strobes and SDA drive are registered (+1 cycle).
// Backpressure: rx_full at the 8th data bit NACKs the byte (no strobe); an empty tx source at load time sends 8'hFF.
module i2c_target_responder #(
    parameter logic [6:0] OWN_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       axi_clk,
    input  logic       axi_reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic       rx_full,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_underrun,
    output logic       busy,
    output logic       rw,
    output logic       stop_seen
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    // Input conditioning: synchroniser stages, sample history and accepted levels.
    // Reset values model an idle bus (both lines high).
    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_lvl, sda_lvl;

    // Synchronise both lines and accept a level only after FILTER_LEN equal samples.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_lvl  <= 1'b1;
            sda_lvl  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
            if ((&scl_hist) || !(|scl_hist)) scl_lvl <= scl_hist[0];
            if ((&sda_hist) || !(|sda_hist)) sda_lvl <= sda_hist[0];
        end
    end

    // Edge pulses fire in the cycle the filtered level is about to change.
    logic scl_rise, scl_fall, sda_rise, sda_fall, bus_start, bus_stop;
    assign scl_rise  = (&scl_hist) & ~scl_lvl;
    assign scl_fall  = ~(|scl_hist) & scl_lvl;
    assign sda_rise  = (&sda_hist) & ~sda_lvl;
    assign sda_fall  = ~(|sda_hist) & sda_lvl;
    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    // Protocol state. ack_drv: in an ACK slot, the first scl_fall has been seen
    // (TX_ACK reuses it as "initiator ACKed, load on next scl_fall").
    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       ack_drv, ack_drv_n;
    logic       ack_ok, ack_ok_n;
    logic       first_pend, first_pend_n;
    logic       drive_n, busy_n, rw_n, rx_valid_n, rx_first_n;
    logic       tx_req_n, tx_under_n, stop_n;
    logic [7:0] rx_data_n;
    logic [7:0] rx_byte, load_byte;

    assign rx_byte   = {shreg[6:0], sda_lvl};
    assign load_byte = tx_valid ? tx_data : 8'hFF;

    // State and registered outputs; reset releases SDA and drops every strobe.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shreg         <= 8'd0;
            ack_drv       <= 1'b0;
            ack_ok        <= 1'b0;
            first_pend    <= 1'b0;
            sda_drive_low <= 1'b0;
            busy          <= 1'b0;
            rw            <= 1'b0;
            rx_data       <= 8'd0;
            rx_valid      <= 1'b0;
            rx_first      <= 1'b0;
            tx_req        <= 1'b0;
            tx_underrun   <= 1'b0;
            stop_seen     <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            ack_drv       <= ack_drv_n;
            ack_ok        <= ack_ok_n;
            first_pend    <= first_pend_n;
            sda_drive_low <= drive_n;
            busy          <= busy_n;
            rw            <= rw_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            rx_first      <= rx_first_n;
            tx_req        <= tx_req_n;
            tx_underrun   <= tx_under_n;
            stop_seen     <= stop_n;
        end
    end

    // Next-state logic: bus conditions first, then per-state SCL edge handling.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        ack_drv_n    = ack_drv;
        ack_ok_n     = ack_ok;
        first_pend_n = first_pend;
        drive_n      = sda_drive_low;
        busy_n       = busy;
        rw_n         = rw;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        rx_first_n   = 1'b0;
        tx_req_n     = 1'b0;
        tx_under_n   = 1'b0;
        stop_n       = 1'b0;

        if (bus_stop) begin
            stop_n    = 1'b1;
            state_n   = IDLE;
            busy_n    = 1'b0;
            drive_n   = 1'b0;
            ack_drv_n = 1'b0;
        end else if (bus_start) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            busy_n    = 1'b0;
            drive_n   = 1'b0;
            ack_drv_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drive_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == OWN_ADDR) begin
                                rw_n      = rx_byte[0];
                                busy_n    = 1'b1;
                                tx_req_n  = rx_byte[0];
                                ack_drv_n = 1'b0;
                                state_n   = ADDR_ACK;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            drive_n   = 1'b1;
                            ack_drv_n = 1'b1;
                        end else begin
                            ack_drv_n = 1'b0;
                            bit_cnt_n = 3'd0;
                            if (rw) begin
                                // First read byte goes out on the same edge that ends the ACK.
                                shreg_n    = load_byte;
                                drive_n    = ~load_byte[7];
                                tx_under_n = ~tx_valid;
                                state_n    = TX_BYTE;
                            end else begin
                                drive_n      = 1'b0;
                                first_pend_n = 1'b1;
                                state_n      = RX_BYTE;
                            end
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (!rx_full) begin
                                rx_data_n    = rx_byte;
                                rx_valid_n   = 1'b1;
                                rx_first_n   = first_pend;
                                first_pend_n = 1'b0;
                                ack_ok_n     = 1'b1;
                            end else begin
                                ack_ok_n = 1'b0;
                            end
                            ack_drv_n = 1'b0;
                            state_n   = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            drive_n   = ack_ok;
                            ack_drv_n = 1'b1;
                        end else begin
                            drive_n   = 1'b0;
                            ack_drv_n = 1'b0;
                            bit_cnt_n = 3'd0;
                            state_n   = ack_ok ? RX_BYTE : WAIT_STOP;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            drive_n   = 1'b0;
                            ack_drv_n = 1'b0;
                            state_n   = TX_ACK;
                        end else begin
                            shreg_n = {shreg[6:0], 1'b0};
                            drive_n = ~shreg[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (!ack_drv && scl_rise) begin
                        if (!sda_lvl) begin
                            tx_req_n  = 1'b1;
                            ack_drv_n = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else if (ack_drv && scl_fall) begin
                        shreg_n    = load_byte;
                        drive_n    = ~load_byte[7];
                        tx_under_n = ~tx_valid;
                        ack_drv_n  = 1'b0;
                        bit_cnt_n  = 3'd0;
                        state_n    = TX_BYTE;
                    end
                end
                WAIT_STOP: begin
                    drive_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    drive_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: bit-banged initiator on an open-drain SDA model.
// Each bit is four quarter-phases of Q cycles, long enough to cover the input filter latency.
// Strobes are tallied by a monitor; each scenario task compares deltas against hand-computed values.
module tb_i2c_target_responder;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst, scl_m, sda_m, rx_full, tx_valid;
    logic [7:0] tx_data;
    logic       scl_in, sda_in, sda_drive_low;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, tx_req, tx_underrun, busy, rw, stop_seen;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_drive_low;

    i2c_target_responder #(.OWN_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .axi_clk      (clk),
        .axi_reset    (rst),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .sda_drive_low(sda_drive_low),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_first     (rx_first),
        .rx_full      (rx_full),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_underrun  (tx_underrun),
        .busy         (busy),
        .rw           (rw),
        .stop_seen    (stop_seen)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         rx_cnt = 0, txreq_cnt = 0, under_cnt = 0, stop_cnt = 0, drv_cnt = 0, both_cnt = 0;
    logic [7:0] rx_log [0:31];
    logic       rx_first_log [0:31];

    // Monitor: tally strobes on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 32) begin
                rx_log[rx_cnt]       <= rx_data;
                rx_first_log[rx_cnt] <= rx_first;
            end
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req)                txreq_cnt <= txreq_cnt + 1;
        if (tx_underrun)           under_cnt <= under_cnt + 1;
        if (stop_seen)             stop_cnt  <= stop_cnt + 1;
        if (sda_drive_low)         drv_cnt   <= drv_cnt + 1;
        if (rx_valid && stop_seen) both_cnt  <= both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic bus_rstart();
        tick(Q); sda_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(4 * Q);
    endtask

    task automatic bit_cyc(input logic b, output logic r);
        tick(Q); sda_m = b;
        tick(Q); scl_m = 1'b1;
        tick(Q);
        @(negedge clk) r = sda_in;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cyc(d[i], r);
        bit_cyc(1'b1, r);
        acked = ~r;
    endtask

    task automatic rd_bits(output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, r);
            d[i] = r;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        n_checks++;
        if (sda_drive_low !== 1'b0) begin
            n_errors++; $display("FAIL reset_sda got=%b exp=0", sda_drive_low);
        end
        n_checks++;
        if ({rx_valid, rx_first, tx_req, tx_underrun, stop_seen} !== 5'b0) begin
            n_errors++; $display("FAIL reset_strobes got=%b exp=00000", {rx_valid, rx_first, tx_req, tx_underrun, stop_seen});
        end
        n_checks++;
        if ({busy, rw, rx_data} !== 10'b0) begin
            n_errors++; $display("FAIL reset_state got=%h exp=000", {busy, rw, rx_data});
        end
        rst = 1'b0;
        tick(10);
    endtask

    task automatic test_write();
        logic a1, a2, a3;
        int   r0, s0;
        r0 = rx_cnt; s0 = stop_cnt;
        bus_start();
        send_byte(8'hA0, a1);
        send_byte(8'h12, a2);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
        send_byte(8'h34, a3);
        bus_stop();
        n_checks++;
        if ({a1, a2, a3} !== 3'b111) begin n_errors++; $display("FAIL wr_acks got=%b exp=111", {a1, a2, a3}); end
        n_checks++;
        if (rx_cnt - r0 !== 2) begin n_errors++; $display("FAIL wr_rx_count got=%0d exp=2", rx_cnt - r0); end
        n_checks++;
        if ({rx_log[r0], rx_first_log[r0]} !== {8'h12, 1'b1}) begin
            n_errors++; $display("FAIL wr_byte0 got=%h/%b exp=12/1", rx_log[r0], rx_first_log[r0]);
        end
        n_checks++;
        if ({rx_log[r0+1], rx_first_log[r0+1]} !== {8'h34, 1'b0}) begin
            n_errors++; $display("FAIL wr_byte1 got=%h/%b exp=34/0", rx_log[r0+1], rx_first_log[r0+1]);
        end
        n_checks++;
        if (stop_cnt - s0 !== 1) begin n_errors++; $display("FAIL wr_stop got=%0d exp=1", stop_cnt - s0); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_addr_mismatch();
        logic a1, a2;
        int   r0, d0;
        r0 = rx_cnt; d0 = drv_cnt;
        bus_start();
        send_byte(8'h84, a1);
        send_byte(8'h55, a2);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL nm_busy got=%b exp=0", busy); end
        bus_stop();
        n_checks++;
        if (drv_cnt - d0 !== 0) begin n_errors++; $display("FAIL nm_drive_cycles got=%0d exp=0", drv_cnt - d0); end
        n_checks++;
        if (rx_cnt - r0 !== 0) begin n_errors++; $display("FAIL nm_rx_count got=%0d exp=0", rx_cnt - r0); end
        n_checks++;
        if ({a1, a2} !== 2'b00) begin n_errors++; $display("FAIL nm_acks got=%b exp=00", {a1, a2}); end
    endtask

    task automatic test_read();
        logic       a, r;
        logic [7:0] d1, d2;
        int         t0;
        t0 = txreq_cnt;
        tx_data = 8'h5A; tx_valid = 1'b1;
        bus_start();
        send_byte(8'hA1, a);
        rd_bits(d1);
        tx_data = 8'hC3;
        bit_cyc(1'b0, r);
        rd_bits(d2);
        bit_cyc(1'b1, r);
        tick(3 * Q);
        @(negedge clk);
        n_checks++;
        if (a !== 1'b1) begin n_errors++; $display("FAIL rd_addr_ack got=%b exp=1", a); end
        n_checks++;
        if (d1 !== 8'h5A) begin n_errors++; $display("FAIL rd_byte0 got=%h exp=5a", d1); end
        n_checks++;
        if (d2 !== 8'hC3) begin n_errors++; $display("FAIL rd_byte1 got=%h exp=c3", d2); end
        n_checks++;
        if (txreq_cnt - t0 !== 2) begin n_errors++; $display("FAIL rd_tx_req got=%0d exp=2", txreq_cnt - t0); end
        n_checks++;
        if ({sda_drive_low, busy, rw} !== 3'b011) begin
            n_errors++; $display("FAIL rd_wait_stop drive/busy/rw got=%b exp=011", {sda_drive_low, busy, rw});
        end
        bus_stop();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_underrun();
        logic       a, r;
        logic [7:0] d;
        int         u0;
        u0 = under_cnt;
        tx_valid = 1'b0; tx_data = 8'h00;
        bus_start();
        send_byte(8'hA1, a);
        rd_bits(d);
        bit_cyc(1'b1, r);
        bus_stop();
        n_checks++;
        if (d !== 8'hFF) begin n_errors++; $display("FAIL ur_byte got=%h exp=ff", d); end
        n_checks++;
        if (under_cnt - u0 !== 1) begin n_errors++; $display("FAIL ur_pulses got=%0d exp=1", under_cnt - u0); end
    endtask

    task automatic test_rx_full();
        logic a1, a2;
        int   r0;
        r0 = rx_cnt;
        rx_full = 1'b1;
        bus_start();
        send_byte(8'hA0, a1);
        send_byte(8'h66, a2);
        rx_full = 1'b0;
        bus_stop();
        n_checks++;
        if ({a1, a2} !== 2'b10) begin n_errors++; $display("FAIL full_acks got=%b exp=10", {a1, a2}); end
        n_checks++;
        if (rx_cnt - r0 !== 0) begin n_errors++; $display("FAIL full_rx_count got=%0d exp=0", rx_cnt - r0); end
    endtask

    task automatic test_repeated_start();
        logic       a1, a2, a3, r;
        logic [7:0] d;
        int         r0, t0;
        r0 = rx_cnt; t0 = txreq_cnt;
        tx_data = 8'h3C; tx_valid = 1'b1;
        bus_start();
        send_byte(8'hA0, a1);
        send_byte(8'h07, a2);
        @(negedge clk);
        n_checks++;
        if ({busy, rw} !== 2'b10) begin n_errors++; $display("FAIL rs_before busy/rw got=%b exp=10", {busy, rw}); end
        bus_rstart();
        send_byte(8'hA1, a3);
        @(negedge clk);
        n_checks++;
        if ({busy, rw} !== 2'b11) begin n_errors++; $display("FAIL rs_after busy/rw got=%b exp=11", {busy, rw}); end
        n_checks++;
        if ({a1, a2, a3} !== 3'b111) begin n_errors++; $display("FAIL rs_acks got=%b exp=111", {a1, a2, a3}); end
        n_checks++;
        if (txreq_cnt - t0 !== 1) begin n_errors++; $display("FAIL rs_tx_req got=%0d exp=1", txreq_cnt - t0); end
        n_checks++;
        if (rx_cnt - r0 !== 1 || rx_log[r0] !== 8'h07 || rx_first_log[r0] !== 1'b1) begin
            n_errors++; $display("FAIL rs_rx got=%0d/%h/%b exp=1/07/1", rx_cnt - r0, rx_log[r0], rx_first_log[r0]);
        end
        rd_bits(d);
        bit_cyc(1'b1, r);
        bus_stop();
        n_checks++;
        if (d !== 8'h3C) begin n_errors++; $display("FAIL rs_read got=%h exp=3c", d); end
    endtask

    task automatic test_reset_and_glitch();
        logic a, a2, r;
        int   r0;
        bus_start();
        send_byte(8'hA0, a);
        for (int i = 7; i >= 0; i--) bit_cyc(1'b1, r);
        tick(Q);
        @(negedge clk);
        n_checks++;
        if (sda_drive_low !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre got=%b exp=1", sda_drive_low); end
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sda_drive_low, busy} !== 2'b00) begin
            n_errors++; $display("FAIL rst_mid_post drive/busy got=%b exp=00", {sda_drive_low, busy});
        end
        rst = 1'b0;
        bus_stop();
        r0 = rx_cnt;
        bus_start();
        tick(Q);
        @(posedge clk) scl_m = 1'b1;
        @(posedge clk) scl_m = 1'b0;
        send_byte(8'hA0, a);
        send_byte(8'h5A, a2);
        bus_stop();
        n_checks++;
        if ({a, a2} !== 2'b11) begin n_errors++; $display("FAIL glitch_acks got=%b exp=11", {a, a2}); end
        n_checks++;
        if (rx_cnt - r0 !== 1 || rx_log[r0] !== 8'h5A) begin
            n_errors++; $display("FAIL glitch_rx got=%0d/%h exp=1/5a", rx_cnt - r0, rx_log[r0]);
        end
        n_checks++;
        if (both_cnt !== 0) begin n_errors++; $display("FAIL rxv_stop_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        rx_full = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_underrun();
        test_rx_full();
        test_repeated_start();
        test_reset_and_glitch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
